// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and transmit-feeder FSM encoding.
// Reused by uart_top and uart_tx_feeder.
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int STATE_W    = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer-side write port, status flags and uart_top launch handshake of the feeder.
// slave = feeder view, master = producer / uart_top view.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DATA_W_DEF
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              clr_ovf;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              start_tx;
  logic [DATA_W-1:0] tx_data_in;
  logic              tx_busy;
  logic              tx_done;
  logic [15:0]       bytes_sent;

  modport slave (
    input  wr_en, wr_data, clr_ovf, tx_busy, tx_done,
    output full, empty, count, overflow, start_tx, tx_data_in, bytes_sent
  );

  modport master (
    output wr_en, wr_data, clr_ovf, tx_busy, tx_done,
    input  full, empty, count, overflow, start_tx, tx_data_in, bytes_sent
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO; full/empty derive from the occupancy counter only.
// A push while full is accepted only when a pop happens at the same edge.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop_ok)  head <= head + PTR_W'(1);
      if (push_ok && !pop_ok)
        count <= count + CNT_W'(1);
      else if (!push_ok && pop_ok)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= push_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to uart_top,
// counting completed frames in bytes_sent.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_feeder_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            state;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] tx_data;
  logic              start_tx;
  logic              overflow;
  logic [15:0]       bytes_sent;

  // Pop decision uses the registered empty flag, so a byte is never popped at the edge that stores it.
  assign pop  = (state == ST_IDLE) && !fifo_empty && !bus.tx_busy;
  assign drop = bus.wr_en && fifo_full && !pop;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A dropped write wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)              overflow <= 1'b0;
    else if (drop)        overflow <= 1'b1;
    else if (bus.clr_ovf) overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      start_tx   <= 1'b0;
      tx_data    <= '0;
      bytes_sent <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data  <= head_data;
            start_tx <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (bus.tx_busy) begin
            start_tx <= 1'b0;
            state    <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.tx_done) begin
            bytes_sent <= bytes_sent + 16'd1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          start_tx <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.full       = fifo_full;
  assign bus.empty      = fifo_empty;
  assign bus.count      = fifo_count;
  assign bus.overflow   = overflow;
  assign bus.start_tx   = start_tx;
  assign bus.tx_data_in = tx_data;
  assign bus.bytes_sent = bytes_sent;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus a randomized run, with a
// queue-based reference model and a small uart_top responder.
module tb_uart_tx_feeder;

  localparam int DEPTH    = 16;
  localparam int P_IDLE   = 0;
  localparam int P_LAUNCH = 1;
  localparam int P_WAIT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DEPTH(DEPTH), .DATA_W(8)) bus ();

  uart_tx_feeder #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model
  logic [7:0] m_q[$];
  logic [7:0] m_popped[$];
  int         m_phase;
  logic       m_ovf;
  logic       m_start;
  logic [7:0] m_data;
  int         m_sent;

  // uart_top responder
  int         stub_cnt    = 0;
  logic       force_busy  = 1'b0;
  logic       spur_done   = 1'b0;
  logic [7:0] rx_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic w, input logic [7:0] d, input logic c, input logic r,
                            input logic busy, input logic done);
    logic pop_now;
    logic was_full;
    logic dropped;
    if (r) begin
      m_q.delete();
      m_phase = P_IDLE;
      m_ovf   = 1'b0;
      m_start = 1'b0;
      m_data  = 8'h00;
      m_sent  = 0;
    end else begin
      pop_now  = (m_phase == P_IDLE) && (m_q.size() != 0) && !busy;
      was_full = (m_q.size() == DEPTH);
      dropped  = w && was_full && !pop_now;
      if (dropped)  m_ovf = 1'b1;
      else if (c)   m_ovf = 1'b0;
      if (pop_now) begin
        m_data  = m_q.pop_front();
        m_popped.push_back(m_data);
        m_start = 1'b1;
        m_phase = P_LAUNCH;
      end else if (m_phase == P_LAUNCH && busy) begin
        m_start = 1'b0;
        m_phase = P_WAIT;
      end else if (m_phase == P_WAIT && done) begin
        m_sent  = (m_sent + 1) % 65536;
        m_phase = P_IDLE;
      end
      if (w && !dropped) m_q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    chk("count",      32'(bus.count),      32'(m_q.size()));
    chk("full",       32'(bus.full),       32'(m_q.size() == DEPTH));
    chk("empty",      32'(bus.empty),      32'(m_q.size() == 0));
    chk("overflow",   32'(bus.overflow),   32'(m_ovf));
    chk("start_tx",   32'(bus.start_tx),   32'(m_start));
    chk("tx_data_in", 32'(bus.tx_data_in), 32'(m_data));
    chk("bytes_sent", 32'(bus.bytes_sent), 32'(m_sent));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic c, input logic r);
    logic       busy_v;
    logic       done_v;
    logic       start_seen;
    logic [7:0] data_seen;
    busy_v = force_busy || (stub_cnt > 0);
    done_v = spur_done || (stub_cnt == 1);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.clr_ovf = c;
    bus.tx_busy = busy_v;
    bus.tx_done = done_v;
    rst         = r;
    start_seen  = bus.start_tx;
    data_seen   = bus.tx_data_in;
    @(posedge clk);
    model_edge(w, d, c, r, busy_v, done_v);
    if (stub_cnt > 0) stub_cnt--;
    else if (start_seen === 1'b1 && !force_busy) begin
      stub_cnt = $urandom_range(2, 6);
      rx_log.push_back(data_seen);
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    rx_log.delete();
    m_popped.delete();
  endtask

  task automatic drain(input int limit);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (m_q.size() == 0 && m_phase == P_IDLE && stub_cnt == 0) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("drain_complete", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [7:0] wr_bytes[$];
    logic       reached;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.clr_ovf = 1'b0;
    bus.tx_busy = 1'b0; bus.tx_done = 1'b0;

    // Reset values
    do_reset();
    chk("rst_count",      32'(bus.count),      32'd0);
    chk("rst_empty",      32'(bus.empty),      32'd1);
    chk("rst_full",       32'(bus.full),       32'd0);
    chk("rst_start_tx",   32'(bus.start_tx),   32'd0);
    chk("rst_tx_data_in", 32'(bus.tx_data_in), 32'd0);

    // Single byte and launch latency
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("lat_edgeN_start", 32'(bus.start_tx), 32'd0);
    chk("lat_edgeN_count", 32'(bus.count),    32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_edgeN1_start", 32'(bus.start_tx),   32'd1);
    chk("lat_edgeN1_data",  32'(bus.tx_data_in), 32'hA5);
    drain(100);
    chk("single_rx_n",   32'(rx_log.size()),   32'd1);
    if (rx_log.size() > 0) chk("single_rx_byte", 32'(rx_log[0]), 32'hA5);
    chk("single_sent",   32'(bus.bytes_sent),  32'd1);
    chk("single_empty",  32'(bus.empty),       32'd1);

    // Spurious tx_done while idle
    spur_done = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    spur_done = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("spur_sent",  32'(bus.bytes_sent), 32'd1);
    chk("spur_start", 32'(bus.start_tx),   32'd0);

    // Burst 0x01..0x10 fills the FIFO, then drains in order
    do_reset();
    force_busy = 1'b1;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("burst_full",  32'(bus.full),  32'd1);
    chk("burst_count", 32'(bus.count), 32'd16);
    force_busy = 1'b0;
    drain(400);
    chk("burst_rx_n", 32'(rx_log.size()), 32'd16);
    for (int i = 0; i < rx_log.size() && i < 16; i++) chk("burst_rx_order", 32'(rx_log[i]), 32'(i + 1));
    chk("burst_sent", 32'(bus.bytes_sent), 32'd16);

    // Overflow with the transmitter held busy
    do_reset();
    wr_bytes.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_bytes.push_back(8'($urandom));
      step(1'b1, wr_bytes[i], 1'b0, 1'b0);
    end
    chk("ovf_count", 32'(bus.count),    32'd16);
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("ovf_clr_vs_drop", 32'(bus.overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
    force_busy = 1'b0;
    drain(400);
    chk("ovf_rx_n", 32'(rx_log.size()), 32'd16);
    for (int i = 0; i < rx_log.size() && i < 16; i++) chk("ovf_rx_byte", 32'(rx_log[i]), 32'(wr_bytes[i]));

    // Write into a full FIFO in the pop cycle
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    force_busy = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("fullpop_count", 32'(bus.count),    32'd16);
    chk("fullpop_ovf",   32'(bus.overflow), 32'd0);
    chk("fullpop_start", 32'(bus.start_tx), 32'd1);
    drain(400);
    chk("fullpop_rx_n", 32'(rx_log.size()), 32'd17);
    if (rx_log.size() > 0) chk("fullpop_last", 32'(rx_log[rx_log.size()-1]), 32'h5A);

    // Reset in WAIT_DONE with 3 bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_phase == P_WAIT) begin reached = 1'b1; break; end
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("midrst_reached_wait", 32'(reached),   32'd1);
    chk("midrst_queued",       32'(bus.count), 32'd3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("midrst_count", 32'(bus.count),      32'd0);
    chk("midrst_empty", 32'(bus.empty),      32'd1);
    chk("midrst_start", 32'(bus.start_tx),   32'd0);
    chk("midrst_data",  32'(bus.tx_data_in), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("midrst_sent_after_done", 32'(bus.bytes_sent), 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
    drain(600);
    chk("rand_rx_n", 32'(rx_log.size()), 32'(m_popped.size()));
    for (int i = 0; i < rx_log.size() && i < m_popped.size(); i++)
      chk("rand_rx_byte", 32'(rx_log[i]), 32'(m_popped[i]));
    chk("rand_sent", 32'(bus.bytes_sent), 32'(m_popped.size() % 65536));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
